// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// divider FSM states and the divide-by-zero quotient constant.
package rv32m_pkg;

    localparam logic [2:0] MD_DIV  = 3'b100;
    localparam logic [2:0] MD_DIVU = 3'b101;
    localparam logic [2:0] MD_REM  = 3'b110;
    localparam logic [2:0] MD_REMU = 3'b111;

    // Wide enough for any supported XLEN; users slice the low XLEN bits.
    localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract the
// divisor when it fits and shift the resulting quotient bit in.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_divisor_ext;

    assign w_shifted     = {i_rem[XLEN-1:0], i_quo[XLEN-1]};
    assign w_divisor_ext = {1'b0, i_divisor};

    // Restore-or-subtract decision for this bit
    always_comb begin
        o_rem = w_shifted;
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (w_shifted >= w_divisor_ext) begin
            o_rem = w_shifted - w_divisor_ext;
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem = w_shifted;
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative RV32M divider: accepts one DIV/DIVU/REM/REMU request, runs XLEN
// restoring steps, applies sign correction and holds the result until taken.
module seq_divider
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] W_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] W_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] W_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [CW-1:0]   r_count;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_resp_data;

    logic            w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special, w_accept;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_data, w_fix_data;
    logic [XLEN:0]   w_rem_next;
    logic [XLEN-1:0] w_quo_next;

    assign w_signed  = ~req_op[0];
    assign w_a_neg   = w_signed & req_a[XLEN-1];
    assign w_b_neg   = w_signed & req_b[XLEN-1];
    assign w_abs_a   = w_a_neg ? (W_ZERO - req_a) : req_a;
    assign w_abs_b   = w_b_neg ? (W_ZERO - req_b) : req_b;
    assign w_b_zero  = (req_b == W_ZERO);
    assign w_ovf     = w_signed & (req_a == W_MIN) & (req_b == W_ONES);
    assign w_special = ~req_op[2] | w_b_zero | w_ovf;
    assign w_accept  = (r_state == ST_IDLE) & req_valid & ~kill;

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_DONE);
    assign resp_data  = r_resp_data;

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    // Results that bypass the iteration: illegal op, divide by zero, signed overflow
    always_comb begin
        w_special_data = W_ZERO;
        if (!req_op[2]) begin
            w_special_data = W_ZERO;
        end else if (w_b_zero) begin
            w_special_data = req_op[1] ? req_a : DIV0_QUOT[XLEN-1:0];
        end else begin
            w_special_data = req_op[1] ? W_ZERO : W_MIN;
        end
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        w_fix_data = W_ZERO;
        if (r_is_rem) begin
            w_fix_data = r_neg_r ? (W_ZERO - r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
        end else begin
            w_fix_data = r_neg_q ? (W_ZERO - r_quo) : r_quo;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; kill outranks every handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_special ? ST_DONE : ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == CNT_ONE) begin
                    w_state_next = ST_FIX;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_FIX: begin
                w_state_next = kill ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (kill || resp_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem       <= {(XLEN+1){1'b0}};
            r_quo       <= W_ZERO;
            r_divisor   <= W_ZERO;
            r_count     <= {CW{1'b0}};
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_resp_data <= W_ZERO;
        end else if (w_accept) begin
            r_rem     <= {(XLEN+1){1'b0}};
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_count   <= CNT_INIT;
            r_is_rem  <= req_op[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            if (w_special) begin
                r_resp_data <= w_special_data;
            end
        end else if (r_state == ST_CALC && !kill) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count - CNT_ONE;
        end else if (r_state == ST_FIX && !kill) begin
            r_resp_data <= w_fix_data;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, back-pressure,
// kill and reset recovery against hand-computed values.
module tb_seq_divider;
    import rv32m_pkg::*;

    localparam int XLEN        = 32;
    localparam int LAT_NORMAL  = XLEN + 1;  // edges after the accept edge
    localparam int LAT_SPECIAL = 0;         // valid in the cycle right after accept

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'b000;
    logic [XLEN-1:0] req_a = 32'h0;
    logic [XLEN-1:0] req_b = 32'h0;
    logic            kill = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        issue(op, a, b);
        wait_resp(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, resp_data, exp);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int lat;
        int stray;

        repeat (2) tick();
        reset = 1'b0;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);

        run("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORMAL);
        run("remu_100_7", MD_REMU, 32'd100, 32'd7, 32'd2, LAT_NORMAL);
        run("div_m7_2",   MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORMAL);
        run("rem_m7_2",   MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORMAL);
        run("rem_7_m2",   MD_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORMAL);
        run("div_m8_m2",  MD_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, LAT_NORMAL);
        run("divu_big",   MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, LAT_NORMAL);
        run("div_5_0",    MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
        run("remu_5_0",   MD_REMU, 32'd5, 32'd0, 32'd5, LAT_SPECIAL);
        run("div_ovf",    MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
        run("rem_ovf",    MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SPECIAL);
        run("illegal_op", 3'b001,  32'd100, 32'd7, 32'h0, LAT_SPECIAL);

        // Back-pressure in DONE, with a competing request that must be ignored
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_resp(lat);
        check("bp_lat", lat, LAT_NORMAL);
        req_op    = MD_DIVU;
        req_a     = 32'd9;
        req_b     = 32'd3;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_hold", {31'h0, resp_valid}, 32'h1);
            check("bp_data_hold", resp_data, 32'd14);
            check("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_valid_drop", {31'h0, resp_valid}, 32'h0);
        check("bp_idle", {31'h0, req_ready}, 32'h1);
        check("bp_data_kept", resp_data, 32'd14);

        // kill during the tenth CALC cycle
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", {31'h0, busy}, 32'h0);
        check("kill_ready", {31'h0, req_ready}, 32'h1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) stray++;
            tick();
        end
        check("kill_no_resp", stray, 0);
        run("after_kill", MD_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORMAL);

        // Same again with reset instead of kill
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_ready", {31'h0, req_ready}, 32'h1);
        check("reset_valid", {31'h0, resp_valid}, 32'h0);
        check("reset_data", resp_data, 32'h0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) stray++;
            tick();
        end
        check("reset_no_resp", stray, 0);
        run("after_reset", MD_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORMAL);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
